// File: rtl/pika_game_pkg.sv
// Constants shared by the volleyball game blocks: Game_state encodings,
// video buffer geometry, net geometry and ball sprite size.
package pika_game_pkg;

  localparam logic [1:0] GS_START = 2'd0;
  localparam logic [1:0] GS_WAIT  = 2'd1;
  localparam logic [1:0] GS_PLAY  = 2'd2;
  localparam logic [1:0] GS_END   = 2'd3;

  localparam int VBUF_W    = 320;
  localparam int VBUF_H    = 240;
  localparam int NET_POS_X = 160;
  localparam int NET_W     = 6;
  localparam int BALL_W    = 30;
  localparam int BALL_H    = 30;

endpackage

// File: rtl/rally_controller_frame_timer.sv
// Counts frame_tick pulses while enabled; done flags the tick that reaches
// count_max, at which point the count wraps back to zero.
module frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] count_max,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = en && tick && (cnt_q == count_max - 1'b1);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rally_controller.sv
// Match sequencer: serve/play/point pacing, landing detection, scoring and
// match end. All outputs are registered from the next-state logic.
module rally_controller
  import pika_game_pkg::*;
#(
  parameter int FLOOR_Y      = 220,
  parameter int NET_CENTER_X = 163,
  parameter int SERVE_TICKS  = 60,
  parameter int POINT_TICKS  = 90,
  parameter int WIN_SCORE    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic        frame_tick,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse
);

  typedef enum logic [2:0] {ST_IDLE, ST_SERVE, ST_PLAY, ST_POINT, ST_END} state_e;

  state_e      state_q, state_d;
  logic [1:0]  game_state_q, game_state_d;
  logic        who_win_q, who_win_d;
  logic [3:0]  player_score_q, player_score_d;
  logic [3:0]  npc_score_q, npc_score_d;
  logic        point_pulse_q, point_pulse_d;
  logic        first_play_q, first_play_d;
  logic        btn_q;

  logic        btn_rise;
  logic        timer_clr, timer_en, timer_done;
  logic [7:0]  timer_max;
  logic [12:0] ball_bottom, ball_cx;
  logic        landing, npc_court;
  logic [3:0]  score_inc;

  function automatic logic [1:0] gs_of(state_e s);
    case (s)
      ST_SERVE, ST_POINT: gs_of = GS_WAIT;
      ST_PLAY:            gs_of = GS_PLAY;
      ST_END:             gs_of = GS_END;
      default:            gs_of = GS_START;
    endcase
  endfunction

  frame_timer #(.CNT_W(8)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (timer_clr),
    .en        (timer_en),
    .tick      (frame_tick),
    .count_max (timer_max),
    .done      (timer_done)
  );

  // 13-bit sums so a ball near the 12-bit limit cannot wrap past the floor or net.
  always_comb begin
    ball_bottom = {1'b0, Ball_Y} + 13'(BALL_H);
    ball_cx     = {1'b0, Ball_X} + 13'(BALL_W / 2);
    landing     = ball_bottom >= 13'(FLOOR_Y);
    npc_court   = ball_cx < 13'(NET_CENTER_X);
    btn_rise    = start_btn && !btn_q;
    timer_en    = (state_q == ST_SERVE) || (state_q == ST_POINT);
    timer_max   = (state_q == ST_SERVE) ? 8'(SERVE_TICKS) : 8'(POINT_TICKS);
  end

  always_comb begin
    state_d        = state_q;
    who_win_d      = who_win_q;
    player_score_d = player_score_q;
    npc_score_d    = npc_score_q;
    point_pulse_d  = 1'b0;
    first_play_d   = 1'b0;
    timer_clr      = 1'b0;
    score_inc      = '0;
    case (state_q)
      ST_IDLE: begin
        if (btn_rise) begin
          state_d   = ST_SERVE;
          timer_clr = 1'b1;
        end
      end
      ST_SERVE: begin
        if (timer_done) begin
          state_d      = ST_PLAY;
          timer_clr    = 1'b1;
          first_play_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // The ball block still shows the serve position on the first PLAY cycle.
        if (!first_play_q && landing) begin
          point_pulse_d = 1'b1;
          timer_clr     = 1'b1;
          if (npc_court) begin
            score_inc      = player_score_q + 4'd1;
            player_score_d = score_inc;
            who_win_d      = 1'b0;
          end else begin
            score_inc   = npc_score_q + 4'd1;
            npc_score_d = score_inc;
            who_win_d   = 1'b1;
          end
          state_d = (score_inc == 4'(WIN_SCORE)) ? ST_END : ST_POINT;
        end
      end
      ST_POINT: begin
        if (timer_done) begin
          state_d   = ST_SERVE;
          timer_clr = 1'b1;
        end
      end
      ST_END: begin
        if (btn_rise) begin
          state_d        = ST_SERVE;
          timer_clr      = 1'b1;
          player_score_d = '0;
          npc_score_d    = '0;
          who_win_d      = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        timer_clr = 1'b1;
      end
    endcase
    game_state_d = gs_of(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      game_state_q   <= GS_START;
      who_win_q      <= 1'b0;
      player_score_q <= '0;
      npc_score_q    <= '0;
      point_pulse_q  <= 1'b0;
      first_play_q   <= 1'b0;
      btn_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      game_state_q   <= game_state_d;
      who_win_q      <= who_win_d;
      player_score_q <= player_score_d;
      npc_score_q    <= npc_score_d;
      point_pulse_q  <= point_pulse_d;
      first_play_q   <= first_play_d;
      btn_q          <= start_btn;
    end
  end

  assign Game_state   = game_state_q;
  assign who_win      = who_win_q;
  assign player_score = player_score_q;
  assign npc_score    = npc_score_q;
  assign point_pulse  = point_pulse_q;

endmodule

// File: tb/tb_rally_controller.sv
// Bench for rally_controller: directed match scenarios then random play,
// every cycle compared against a rule-level model of the match.
module tb_rally_controller;

  localparam int SERVE_N = 60;
  localparam int POINT_N = 90;
  localparam int WIN_N   = 5;

  logic        clk;
  logic        reset_n;
  logic        start_btn;
  logic        frame_tick;
  logic [11:0] Ball_X;
  logic [11:0] Ball_Y;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;

  int total = 0;
  int bad   = 0;

  // Model: match phase as words of the rules, plus counters.
  typedef enum int {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_END} mphase_e;
  mphase_e m_phase;
  int      m_ticks, m_play_age, m_p, m_n, m_who, m_pulse;
  bit      m_btn_prev;

  rally_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_btn    (start_btn),
    .frame_tick   (frame_tick),
    .Ball_X       (Ball_X),
    .Ball_Y       (Ball_Y),
    .Game_state   (Game_state),
    .who_win      (who_win),
    .player_score (player_score),
    .npc_score    (npc_score),
    .point_pulse  (point_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_gs();
    case (m_phase)
      M_SERVE, M_POINT: return 1;
      M_PLAY:           return 2;
      M_END:            return 3;
      default:          return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_ticks = 0; m_play_age = 0;
    m_p = 0; m_n = 0; m_who = 0; m_pulse = 0; m_btn_prev = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    rise = start_btn && !m_btn_prev;
    m_btn_prev = start_btn;
    m_pulse = 0;
    case (m_phase)
      M_IDLE: if (rise) begin m_phase = M_SERVE; m_ticks = 0; end
      M_SERVE: if (frame_tick) begin
        m_ticks++;
        if (m_ticks == SERVE_N) begin m_phase = M_PLAY; m_play_age = 0; m_ticks = 0; end
      end
      M_PLAY: begin
        if (m_play_age > 0 && int'(Ball_Y) + 30 >= 220) begin
          m_pulse = 1;
          if (int'(Ball_X) + 15 < 163) begin m_p++; m_who = 0; end
          else begin m_n++; m_who = 1; end
          m_phase = (m_p == WIN_N || m_n == WIN_N) ? M_END : M_POINT;
          m_ticks = 0;
        end
        m_play_age++;
      end
      M_POINT: if (frame_tick) begin
        m_ticks++;
        if (m_ticks == POINT_N) begin m_phase = M_SERVE; m_ticks = 0; end
      end
      M_END: if (rise) begin
        m_p = 0; m_n = 0; m_who = 0; m_phase = M_SERVE; m_ticks = 0;
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    check("game_state", int'(Game_state), exp_gs());
    check("who_win", int'(who_win), m_who);
    check("player_score", int'(player_score), m_p);
    check("npc_score", int'(npc_score), m_n);
    check("point_pulse", int'(point_pulse), m_pulse);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Serve position held, one tick per cycle, until the model reaches PLAY.
  task automatic go_play();
    int n;
    Ball_X = 12'd40; Ball_Y = 12'd50; frame_tick = 1'b1;
    n = 0;
    while (m_phase != M_PLAY && n < 400) begin cyc(); n++; end
    check("reach_play", int'(m_phase == M_PLAY), 1);
    frame_tick = 1'b0;
    cyc();
  endtask

  initial begin
    reset_n = 1'b0; start_btn = 1'b0; frame_tick = 1'b0;
    Ball_X = 12'd40; Ball_Y = 12'd50;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Start edge with a coincident tick; 59 ticks keep the wait, the 60th starts play.
    start_btn = 1'b1; frame_tick = 1'b1;
    cyc();
    check("serve_entry", int'(Game_state), 1);
    start_btn = 1'b0;
    for (int i = 0; i < SERVE_N - 1; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc();
    end
    check("serve_59", int'(Game_state), 1);
    frame_tick = 1'b1; cyc();
    check("serve_60", int'(Game_state), 2);
    frame_tick = 1'b0; cyc();

    // Landing in the NPC court.
    Ball_X = 12'd40; Ball_Y = 12'd190;
    cyc();
    check("p_pulse", int'(point_pulse), 1);
    check("p_score", int'(player_score), 1);
    check("p_who", int'(who_win), 0);
    check("p_gs", int'(Game_state), 1);

    // Landing in the player court held for 100 cycles.
    go_play();
    Ball_X = 12'd200; Ball_Y = 12'd195;
    for (int i = 0; i < 100; i++) cyc();
    check("hold_npc", int'(npc_score), 1);
    check("hold_who", int'(who_win), 1);

    while (m_n < WIN_N - 1) begin
      go_play();
      Ball_X = 12'd200; Ball_Y = 12'd195;
      cyc(); cyc();
    end
    check("npc_4", int'(npc_score), 4);

    // Match point with the button already held; holding it in END does nothing.
    go_play();
    start_btn = 1'b1;
    cyc();
    Ball_X = 12'd200; Ball_Y = 12'd195;
    cyc();
    check("end_gs", int'(Game_state), 3);
    check("end_npc", int'(npc_score), 5);
    for (int i = 0; i < 20; i++) cyc();
    check("end_held", int'(Game_state), 3);
    start_btn = 1'b0; cyc();
    start_btn = 1'b1; cyc();
    check("restart_gs", int'(Game_state), 1);
    check("restart_npc", int'(npc_score), 0);
    check("restart_who", int'(who_win), 0);
    start_btn = 1'b0;

    // Reset in the middle of a rally with player at 3.
    for (int k = 0; k < 3; k++) begin
      go_play();
      Ball_X = 12'd40; Ball_Y = 12'd190;
      cyc(); cyc();
    end
    go_play();
    Ball_X = 12'd100; Ball_Y = 12'd100;
    cyc();
    check("pre_reset_p", int'(player_score), 3);
    do_reset();
    check("rst_gs", int'(Game_state), 0);
    check("rst_p", int'(player_score), 0);

    // Random play, including 12-bit extremes and occasional reset.
    for (int i = 0; i < 6000; i++) begin
      start_btn  = ($urandom_range(0, 15) == 0);
      frame_tick = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       begin Ball_X = 12'($urandom_range(0, 4095)); Ball_Y = 12'($urandom_range(0, 4095)); end
        1, 2:    begin Ball_X = 12'($urandom_range(0, 320)); Ball_Y = 12'($urandom_range(185, 240)); end
        default: begin Ball_X = 12'($urandom_range(0, 320)); Ball_Y = 12'($urandom_range(0, 189)); end
      endcase
      if ($urandom_range(0, 1999) == 0) do_reset();
      else cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
